sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller request port between two requesters: port 0, the ADC capture write stream, and port 1, the host readout path.
Performs round-robin arbitration, latches the winning command, and drives the controller Req/WnR/Address/DataIn handshake. It then waits for completion and routes read data and acknowledgements back to the originating port.
Sits between the ADC capture/readout logic and the SDRAM controller.
Adds watchdog timeout detection with a sticky error flag.

Parameters:
ADDR_W, 22, SDRAM word address width
DATA_W, 16, data word width
TIMEOUT, 1024, max cycles in ISSUE or WAIT before abort
P0_PRIORITY, 0, 1 = port 0 always wins ties (capture must never stall); 0 = round-robin

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
p0_req  in  1  port 0 request, held until p0_ack
p0_wnr  in  1  port 0 write-not-read
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  one-cycle pulse: port 0 command accepted by controller
p0_rdata  out  DATA_W  port 0 read data
p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
p1_req, p1_wnr, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_rvalid  (same as port 0, for port 1)
ctl_req  out  1  to controller Req
ctl_wnr  out  1  to controller WnR
ctl_addr  out  ADDR_W  to controller Address
ctl_wdata  out  DATA_W  to controller DataIn
ctl_busy  in  1  controller Busy
ctl_ack  in  1  controller Ack
ctl_rdata  in  DATA_W  controller DataOut
ctl_rvalid  in  1  controller read-data-valid pulse
err  out  1  sticky timeout error, cleared only by Reset
grant  out  1  index of the port owning the current or last transaction

Behaviour:
- Reset values: all ctl_* outputs 0; all pN_ack and pN_rvalid 0; pN_rdata 0; err 0; grant 1 (so port 0 wins the first round-robin tie); state IDLE; timeout counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If ctl_busy=0 and any pN_req=1: select the winner, latch its wnr/addr/wdata into ctl_*, set ctl_req=1 and grant, and go to ISSUE. ctl_req is high on the cycle after the request is sampled.
  - If ctl_busy=1 (init or refresh in progress): issue nothing.
- Winner selection:
  - Round-robin: the port other than grant wins ties.
  - P0_PRIORITY=1: port 0 always wins ties.
  - A single requester always wins.
- ISSUE:
  - Hold ctl_req and latched fields stable.
  - On ctl_ack=1: ctl_req<=0, pulse p[grant]_ack for exactly one cycle, go to WAIT.
- WAIT, write: done on the first cycle ctl_busy=0, then go to IDLE. A new grant is possible on the following cycle.
- WAIT, read: on ctl_rvalid=1, p[grant]_rdata<=ctl_rdata, pulse p[grant]_rvalid one cycle, go to IDLE. ctl_busy is ignored.
- Minimum request-to-ack latency is 2 cycles (sample, then issue with ctl_ack combinational-next) plus the controller ack delay.
- Requester rule: pN_req must stay high until pN_ack. Deasserting it earlier is a protocol violation; the latched command still completes.
- Back-to-back: a port may keep pN_req high after ack for its next word. In round-robin mode the other port gets the next grant if it is requesting.
- Simultaneous events: ctl_ack and timeout expiry in the same cycle → ack wins, counter cleared.
- Spurious inputs: ctl_rvalid in IDLE/ISSUE, or during a write WAIT, is ignored and not forwarded.
- Timeout:
  - The counter resets on entry to ISSUE and WAIT and increments each cycle while in them.
  - On reaching TIMEOUT-1: err<=1, ctl_req<=0, go to IDLE, no ack/rvalid pulse to the port. The port sees its request unanswered and re-arbitrates.
  - Counter width is clog2(TIMEOUT)+1.
- Reset mid-transaction: aborts immediately to reset values. The controller is reset by the same Reset, so no cleanup handshake is needed.

Decomposition:
- Shared package sdram_pkg: state encodings (IDLE/ISSUE/WAIT), ADDR_W/DATA_W defaults, REFRESH/INIT timing constants shared with the controller.
- One natural sub-module: rr_arbiter2 (combinational 2-way winner select from req[1:0], last grant, and priority mode), instantiated once.

Test Plan:
- Single write: p0_req=1, wnr=1, addr=0x000123, wdata=0xBEEF → ctl_req high next cycle with ctl_addr=0x000123, ctl_wdata=0xBEEF; p0_ack one cycle after ctl_ack; return to IDLE when ctl_busy=0.
- Single read: p1 read at addr=0x3FFFFF; controller returns 0x1234 with ctl_rvalid → p1_rdata=0x1234, p1_rvalid pulses once, p0_rvalid stays 0.
- Contention: both ports request continuously with P0_PRIORITY=0 → grants alternate 0,1,0,1 over 8 transactions. With P0_PRIORITY=1 → all grants go to port 0 while p0_req is held.
- Busy gating: ctl_busy=1 for 50 cycles (refresh) while p0_req=1 → ctl_req stays 0; first ctl_req occurs 1 cycle after ctl_busy falls.
- Timeout: TIMEOUT=16, controller never acks → err=1 after 16 cycles in ISSUE, ctl_req=0, no p0_ack. err stays 1 through later successful transactions until Reset.
- Reset mid-read: assert Reset in WAIT → next cycle all outputs at reset values, no rvalid pulse; a later ctl_rvalid is ignored.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared SDRAM state encodings, widths and timing constants
package sdram_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 16;

  // Controller timing shared with the SDRAM controller (in Clk cycles)
  localparam int INIT_CYCLES      = 20000;
  localparam int REFRESH_INTERVAL = 780;
  localparam int REFRESH_CYCLES   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// rtl/sdram_port_arbiter_rr.sv - combinational two-way winner select
module rr_arbiter2 #(
  parameter bit P0_PRIORITY = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o
);

  // A lone requester always wins; ties go to port 0 or to the port not served last.
  assign winner_o = (&req_i) ? (P0_PRIORITY ? 1'b0 : ~last_grant_i) : ~req_i[0];

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM controller port between capture and readout
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT     = 1024,
  parameter int P0_PRIORITY = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_wnr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_wnr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic              ctl_req,
  output logic              ctl_wnr,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_busy,
  input  logic              ctl_ack,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_rvalid,
  output logic              err,
  output logic              grant
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ctl_req_q;
  logic              ctl_wnr_q;
  logic [ADDR_W-1:0] ctl_addr_q;
  logic [DATA_W-1:0] ctl_wdata_q;
  logic [1:0]        ack_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              err_q;
  logic              grant_q;
  logic              winner;

  rr_arbiter2 #(
    .P0_PRIORITY (P0_PRIORITY != 0)
  ) u_arb (
    .req_i        ({p1_req, p0_req}),
    .last_grant_i (grant_q),
    .winner_o     (winner)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctl_req_q   <= 1'b0;
      ctl_wnr_q   <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err_q       <= 1'b0;
      grant_q     <= 1'b1;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (!ctl_busy && (p0_req || p1_req)) begin
            grant_q     <= winner;
            ctl_req_q   <= 1'b1;
            ctl_wnr_q   <= winner ? p1_wnr : p0_wnr;
            ctl_addr_q  <= winner ? p1_addr : p0_addr;
            ctl_wdata_q <= winner ? p1_wdata : p0_wdata;
            cnt_q       <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Ack is checked first so it beats a watchdog expiry in the same cycle.
          if (ctl_ack) begin
            ctl_req_q      <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            cnt_q          <= '0;
            state_q        <= ST_WAIT;
          end else if (cnt_q == CNT_LAST) begin
            err_q     <= 1'b1;
            ctl_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (ctl_wnr_q ? !ctl_busy : ctl_rvalid) begin
            if (!ctl_wnr_q) begin
              rvalid_q[grant_q] <= 1'b1;
              if (grant_q) rdata1_q <= ctl_rdata;
              else         rdata0_q <= ctl_rdata;
            end
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctl_req   = ctl_req_q;
  assign ctl_wnr   = ctl_wnr_q;
  assign ctl_addr  = ctl_addr_q;
  assign ctl_wdata = ctl_wdata_q;
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign err       = err_q;
  assign grant     = grant_q;

endmodule
